// File: rtl/yuv422_to_444.sv
`default_nettype none
// ---------------------------------------------------------------------------
// yuv422_to_444 : YCbCr 4:2:2 -> 4:4:4 upsampler, chroma replicated per pair
// Revision: 1.0
// ---------------------------------------------------------------------------
module yuv422_to_444 #(
  parameter bit         CB_FIRST  = 1'b1,
  parameter logic [7:0] NEUTRAL_C = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser,
  output logic        phase_err
);

  typedef enum logic [1:0] {
    ST_EVEN  = 2'd0,
    ST_ODD   = 2'd1,
    ST_EMIT1 = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_hold_y;
  logic [7:0]  r_hold_c;
  logic        r_hold_user;
  logic [23:0] r_p1_data;
  logic        r_p1_last;
  logic [23:0] r_m_tdata;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic        r_m_tuser;
  logic        r_phase_err;

  logic        w_out_free;
  logic        w_accept;
  logic [7:0]  w_in_y;
  logic [7:0]  w_in_c;
  logic [23:0] w_pair0;
  logic [23:0] w_pair1;
  logic [23:0] w_pad_held;
  logic [23:0] w_pad_in;

  // Place the even/odd chroma bytes into the {Cr,Cb,Y} output word
  function automatic logic [23:0] pack_pix(input logic [7:0] c_even,
                                           input logic [7:0] c_odd,
                                           input logic [7:0] y);
    if (CB_FIRST) pack_pix = {c_odd, c_even, y};
    else          pack_pix = {c_even, c_odd, y};
  endfunction

  assign w_out_free = !r_m_tvalid || m_axis_video_tready;
  assign s_axis_video_tready = (r_state != ST_EMIT1) && w_out_free;
  assign w_accept   = s_axis_video_tvalid && s_axis_video_tready;
  assign w_in_y     = s_axis_video_tdata[7:0];
  assign w_in_c     = s_axis_video_tdata[15:8];
  assign w_pair0    = pack_pix(r_hold_c, w_in_c, r_hold_y);
  assign w_pair1    = pack_pix(r_hold_c, w_in_c, w_in_y);
  assign w_pad_held = pack_pix(r_hold_c, NEUTRAL_C, r_hold_y);
  assign w_pad_in   = pack_pix(w_in_c, NEUTRAL_C, w_in_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EVEN;
      r_hold_y    <= 8'h00;
      r_hold_c    <= 8'h00;
      r_hold_user <= 1'b0;
      r_p1_data   <= 24'h000000;
      r_p1_last   <= 1'b0;
      r_m_tdata   <= 24'h000000;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tuser   <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_phase_err <= 1'b0;
      // Output beat consumed; cleared unless a new one loads below
      if (w_out_free) r_m_tvalid <= 1'b0;
      case (r_state)
        ST_EVEN: begin
          if (w_accept) begin
            if (s_axis_video_tlast) begin
              r_m_tdata  <= w_pad_in;
              r_m_tvalid <= 1'b1;
              r_m_tlast  <= 1'b1;
              r_m_tuser  <= s_axis_video_tuser;
            end else begin
              r_hold_y    <= w_in_y;
              r_hold_c    <= w_in_c;
              r_hold_user <= s_axis_video_tuser;
              r_state     <= ST_ODD;
            end
          end
        end
        ST_ODD: begin
          if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= r_hold_user;
            if (s_axis_video_tuser) begin
              // SOF mid-pair: flush the orphan and restart the pair on this beat
              r_m_tdata   <= w_pad_held;
              r_phase_err <= 1'b1;
              r_hold_y    <= w_in_y;
              r_hold_c    <= w_in_c;
              r_hold_user <= 1'b1;
            end else begin
              r_m_tdata <= w_pair0;
              r_p1_data <= w_pair1;
              r_p1_last <= s_axis_video_tlast;
              r_state   <= ST_EMIT1;
            end
          end
        end
        ST_EMIT1: begin
          if (r_m_tvalid && m_axis_video_tready) begin
            r_m_tdata  <= r_p1_data;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= r_p1_last;
            r_m_tuser  <= 1'b0;
            r_state    <= ST_EVEN;
          end
        end
        default: r_state <= ST_EVEN;
      endcase
    end
  end

  assign m_axis_video_tdata  = r_m_tdata;
  assign m_axis_video_tvalid = r_m_tvalid;
  assign m_axis_video_tlast  = r_m_tlast;
  assign m_axis_video_tuser  = r_m_tuser;
  assign phase_err           = r_phase_err;

endmodule
`default_nettype wire
